// File: rtl/game_pkg.sv
// Shared game types and constants used by the HUD/bar renderers.
package game_pkg;

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      HIT   = 2'd1,
      DEAD  = 2'd2
   } hp_state_t;

   localparam logic [11:0] YELLOW = 12'hFF0;
   localparam logic [11:0] DRAIN  = 12'hF80;
   localparam logic [11:0] RED    = 12'hF00;
   localparam logic [11:0] BLACK  = 12'h000;

   localparam int SCREEN_W = 1024;
   localparam int SCREEN_H = 768;

endpackage

// File: rtl/hp_meter_frame_pulse.sv
// Frame pulse generator: one registered tick per video frame plus a
// free-running frame counter used for blink timing.
module frame_pulse (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   output logic        frame_tick,
   output logic [7:0]  frame_count
);

   logic origin;
   assign origin = (hcount_in == 11'd0) && (vcount_in == 10'd0);

   // Register the frame-origin strobe and count frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_tick  <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         frame_tick <= origin;
         if (origin) frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: rtl/hp_meter.sv
// Player HP tracker with invincibility frames, a draining HP bar and a
// sticky game-over flag.
module hp_meter
   import game_pkg::*;
#(
   parameter int X         = 480,
   parameter int Y         = 584,
   parameter int WIDTH     = 96,
   parameter int HEIGHT    = 32,
   parameter int MAX_HP    = 24,
   parameter int PX_PER_HP = 4,
   parameter int DAMAGE    = 4,
   parameter int IFRAMES   = 60,
   parameter int DRAIN_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        damage_in,
   output logic [7:0]  hp_out,
   output logic        dead_out,
   output logic [11:0] pixel_out
);

   localparam int IW = $clog2(IFRAMES + 1);
   localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

   logic          frame_tick;
   logic [7:0]    frame_count;
   logic          unused_fc;
   logic          damage_p1;
   logic          hit;
   hp_state_t     state, state_nxt;
   logic [7:0]    hp, hp_nxt, disp_hp;
   logic [IW-1:0] iframe_cnt, iframe_nxt;
   logic [DW-1:0] drain_cnt;
   logic [11:0]   h12, v12, col, hp_px, disp_px, pixel_nxt;
   logic          in_box, blink;

   // Damage saturates at zero so HP can never wrap to a large value.
   function automatic logic [7:0] sat_sub(input logic [7:0] a);
      return (a > 8'(DAMAGE)) ? a - 8'(DAMAGE) : 8'd0;
   endfunction

   // HP units to bar pixels (constant multiply only).
   function automatic logic [11:0] bar_px(input logic [7:0] v);
      return {4'd0, v} * 12'(PX_PER_HP);
   endfunction

   frame_pulse u_frame_pulse (
      .clk         (clk),
      .rst         (rst),
      .hcount_in   (hcount_in),
      .vcount_in   (vcount_in),
      .frame_tick  (frame_tick),
      .frame_count (frame_count)
   );

   assign unused_fc = ^{frame_count[7:3], frame_count[1:0]};

   // Edge detect on damage: a held level only counts once.
   always_ff @(posedge clk) begin
      if (rst) damage_p1 <= 1'b0;
      else     damage_p1 <= damage_in;
   end
   assign hit = damage_in && !damage_p1;

   // FSM and HP state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ALIVE;
         hp         <= 8'(MAX_HP);
         iframe_cnt <= '0;
      end else begin
         state      <= state_nxt;
         hp         <= hp_nxt;
         iframe_cnt <= iframe_nxt;
      end
   end

   // Next-state logic: hits only land in ALIVE; HIT counts down frames.
   always_comb begin
      state_nxt  = state;
      hp_nxt     = hp;
      iframe_nxt = iframe_cnt;
      case (state)
         ALIVE: begin
            if (hit) begin
               hp_nxt     = sat_sub(hp);
               iframe_nxt = IW'(IFRAMES);
               state_nxt  = (hp_nxt == 8'd0) ? DEAD : HIT;
            end
         end
         HIT: begin
            if (frame_tick) begin
               iframe_nxt = iframe_cnt - IW'(1);
               if (iframe_nxt == '0) state_nxt = ALIVE;
            end
         end
         DEAD: ;
         default: state_nxt = ALIVE;
      endcase
   end

   // Displayed bar trails true HP by one unit every DRAIN_DIV frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_hp   <= 8'(MAX_HP);
         drain_cnt <= '0;
      end else if (disp_hp == hp) begin
         drain_cnt <= '0;
      end else if (frame_tick) begin
         if (drain_cnt == DW'(DRAIN_DIV - 1)) begin
            disp_hp   <= disp_hp - 8'd1;
            drain_cnt <= '0;
         end else begin
            drain_cnt <= drain_cnt + DW'(1);
         end
      end
   end

   assign hp_out   = hp;
   assign dead_out = (state == DEAD);

   // Stage p0: box test and column compare on the incoming pixel position.
   assign h12     = {1'b0, hcount_in};
   assign v12     = {2'b0, vcount_in};
   assign col     = h12 - 12'(X);
   assign hp_px   = bar_px(hp);
   assign disp_px = bar_px(disp_hp);
   assign in_box  = (h12 >= 12'(X)) && (h12 < 12'(X + WIDTH)) &&
                    (v12 >= 12'(Y)) && (v12 < 12'(Y + HEIGHT));
   assign blink   = (state == HIT) && frame_count[2];

   // Colour select; exactly zero outside the box since sprites are summed.
   always_comb begin
      pixel_nxt = BLACK;
      if (in_box) begin
         if (col < hp_px)        pixel_nxt = blink ? BLACK : YELLOW;
         else if (col < disp_px) pixel_nxt = DRAIN;
         else                    pixel_nxt = RED;
      end
   end

   // Stage p1: registered pixel output.
   always_ff @(posedge clk) begin
      if (rst) pixel_out <= BLACK;
      else     pixel_out <= pixel_nxt;
   end

endmodule

// File: tb/tb_hp_meter.sv
// Self-checking bench for hp_meter with a behavioural HP/bar model.
module tb_hp_meter;

   localparam int X = 480, Y = 584, W = 96, H = 32;
   localparam int MAX_HP = 24, PX = 4, DMG = 4, IFR = 8, DIV = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, damage;
   logic [10:0] hc;
   logic [9:0]  vc;
   logic [7:0]  hp_out;
   logic        dead_out;
   logic [11:0] pixel_out;

   logic        rst2, dmg2;
   logic [10:0] hc2;
   logic [9:0]  vc2;
   logic [7:0]  hp2;
   logic        dead2;
   logic [11:0] pix2;

   hp_meter #(.IFRAMES(IFR)) dut (
      .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .damage_in(damage),
      .hp_out(hp_out), .dead_out(dead_out), .pixel_out(pixel_out)
   );

   hp_meter #(.MAX_HP(6), .WIDTH(24), .DAMAGE(4), .IFRAMES(IFR)) dut2 (
      .clk(clk), .rst(rst2), .hcount_in(hc2), .vcount_in(vc2), .damage_in(dmg2),
      .hp_out(hp2), .dead_out(dead2), .pixel_out(pix2)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   int          m_hp, m_disp, m_acc, m_ifr, m_fc;
   bit          m_dead, m_prev_org, m_prev_dmg;
   logic [11:0] m_pix;

   task automatic model_reset();
      m_hp = MAX_HP; m_disp = MAX_HP; m_acc = 0; m_ifr = 0; m_fc = 0;
      m_dead = 0; m_prev_org = 0; m_prev_dmg = 0;
   endtask

   // Drive one clock of inputs to dut and advance the model alongside.
   task automatic step(input int h, input int v, input logic d, input logic r);
      bit tick, hit, org;
      int col;
      logic [11:0] pix;
      hc = 11'(h); vc = 10'(v); damage = d; rst = r;
      org = (h == 0 && v == 0);
      pix = 12'h000;
      if (!r && h >= X && h < X + W && v >= Y && v < Y + H) begin
         col = h - X;
         if (col < m_hp * PX)
            pix = (!m_dead && m_ifr > 0 && m_fc[2]) ? 12'h000 : 12'hFF0;
         else if (col < m_disp * PX) pix = 12'hF80;
         else                        pix = 12'hF00;
      end
      @(posedge clk);
      tick = m_prev_org;
      hit  = d && !m_prev_dmg;
      if (r) begin
         model_reset();
      end else begin
         if (m_disp == m_hp) m_acc = 0;
         else if (tick) begin
            m_acc++;
            if (m_acc == DIV) begin m_disp--; m_acc = 0; end
         end
         if (!m_dead) begin
            if (m_ifr > 0) begin
               if (tick) m_ifr--;
            end else if (hit) begin
               m_hp = (m_hp > DMG) ? m_hp - DMG : 0;
               if (m_hp == 0) m_dead = 1;
               else           m_ifr = IFR;
            end
         end
         if (org) m_fc = (m_fc + 1) % 256;
         m_prev_org = org;
         m_prev_dmg = d;
      end
      m_pix = pix;
      #1;
   endtask

   task automatic frame(input logic d, input int col);
      step(0, 0, d, 1'b0);
      step(X + col, Y + 5, d, 1'b0);
   endtask

   task automatic test_reset();
      step(X + 10, Y + 5, 1'b0, 1'b1);
      step(X + 10, Y + 5, 1'b0, 1'b1);
      total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL reset_pix: got %h want 000", pixel_out); end
      total++; if (hp_out !== 8'd24 || dead_out !== 1'b0) begin bad++; $display("FAIL reset_hp: got hp=%0d dead=%0b want 24/0", hp_out, dead_out); end
      step(X + 10, Y + 5, 1'b0, 1'b0);
      total++; if (pixel_out !== 12'hFF0) begin bad++; $display("FAIL pix_in: got %h want FF0", pixel_out); end
      step(X - 1, Y, 1'b0, 1'b0);
      total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL pix_left: got %h want 000", pixel_out); end
      step(X + 95, Y + 31, 1'b0, 1'b0);
      total++; if (pixel_out !== 12'hFF0) begin bad++; $display("FAIL pix_corner: got %h want FF0", pixel_out); end
      step(X + 96, Y, 1'b0, 1'b0);
      total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL pix_right: got %h want 000", pixel_out); end
      step(X, Y + 32, 1'b0, 1'b0);
      total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL pix_below: got %h want 000", pixel_out); end
      step(X, Y - 1, 1'b0, 1'b0);
      total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL pix_above: got %h want 000", pixel_out); end
   endtask

   task automatic test_hold();
      int changes, prev;
      changes = 0;
      prev = hp_out;
      for (int i = 0; i < 50; i++) begin
         step(X + 85, Y + 5, 1'b1, 1'b0);
         if (hp_out != prev) changes++;
         prev = hp_out;
         total++;
         if (hp_out !== 8'(m_hp) || dead_out !== m_dead || pixel_out !== m_pix) begin
            bad++; $display("FAIL hold_track: got hp=%0d dead=%0b pix=%h want %0d/%0b/%h", hp_out, dead_out, pixel_out, m_hp, m_dead, m_pix);
         end
      end
      total++; if (changes != 1 || hp_out !== 8'd20) begin bad++; $display("FAIL hold_once: got changes=%0d hp=%0d want 1/20", changes, hp_out); end
      frame(1'b0, 85);
      frame(1'b0, 85);
      total++; if (pixel_out !== 12'hF80 || pixel_out !== m_pix) begin bad++; $display("FAIL mid_drain: got %h want F80 (model %h)", pixel_out, m_pix); end
   endtask

   task automatic test_iframes();
      frame(1'b1, 85);
      total++; if (hp_out !== 8'd20 || hp_out !== 8'(m_hp)) begin bad++; $display("FAIL iframe_ignore: got %0d want 20", hp_out); end
      for (int f = 0; f < 6; f++) begin
         frame(1'b0, 85);
         total++;
         if (pixel_out !== m_pix || hp_out !== 8'(m_hp)) begin
            bad++; $display("FAIL drain_track: got pix=%h hp=%0d want %h/%0d", pixel_out, hp_out, m_pix, m_hp);
         end
      end
      total++; if (pixel_out !== 12'hF00) begin bad++; $display("FAIL drain_done: got %h want F00", pixel_out); end
      frame(1'b1, 85);
      total++; if (hp_out !== 8'd16) begin bad++; $display("FAIL second_hit: got %0d want 16", hp_out); end
   endtask

   task automatic test_blink();
      int blanks, yellows;
      blanks = 0; yellows = 0;
      for (int f = 0; f < 8; f++) begin
         frame(1'b0, 10);
         if (pixel_out === 12'h000) blanks++;
         if (pixel_out === 12'hFF0) yellows++;
         total++;
         if (pixel_out !== m_pix) begin bad++; $display("FAIL blink_track: got %h want %h", pixel_out, m_pix); end
      end
      total++; if (blanks == 0) begin bad++; $display("FAIL blink_dark: got %0d dark frames want >0", blanks); end
      total++; if (yellows == 0) begin bad++; $display("FAIL blink_lit: got %0d lit frames want >0", yellows); end
   endtask

   task automatic test_reset_mid();
      frame(1'b1, 70);
      frame(1'b0, 70);
      frame(1'b0, 70);
      total++; if (hp_out !== 8'd12 || pixel_out !== m_pix) begin bad++; $display("FAIL pre_rst: got hp=%0d pix=%h want 12/%h", hp_out, pixel_out, m_pix); end
      step(X + 70, Y + 5, 1'b0, 1'b1);
      total++; if (hp_out !== 8'd24 || dead_out !== 1'b0 || pixel_out !== 12'h000) begin bad++; $display("FAIL mid_rst: got hp=%0d dead=%0b pix=%h want 24/0/000", hp_out, dead_out, pixel_out); end
      step(X + 70, Y + 5, 1'b1, 1'b0);
      total++; if (hp_out !== 8'd20 || pixel_out !== 12'hFF0) begin bad++; $display("FAIL rst_hit: got hp=%0d pix=%h want 20/FF0", hp_out, pixel_out); end
      step(X + 70, Y + 5, 1'b0, 1'b0);
      total++; if (pixel_out !== m_pix) begin bad++; $display("FAIL rst_pix: got %h want %h", pixel_out, m_pix); end
   endtask

   task automatic test_death();
      int exp_hp;
      step(X, Y, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         step(X + 50, Y + 5, 1'b1, 1'b0);
         exp_hp = MAX_HP - DMG * (k + 1);
         if (exp_hp < 0) exp_hp = 0;
         total++;
         if (hp_out !== 8'(exp_hp) || dead_out !== (exp_hp == 0)) begin
            bad++; $display("FAIL death_hit%0d: got hp=%0d dead=%0b want %0d/%0b", k, hp_out, dead_out, exp_hp, exp_hp == 0);
         end
         step(X + 50, Y + 5, 1'b0, 1'b0);
         for (int f = 0; f < 9; f++) begin
            frame(1'b0, 50);
            total++;
            if (pixel_out !== m_pix || hp_out !== 8'(m_hp) || dead_out !== m_dead) begin
               bad++; $display("FAIL death_track: got pix=%h hp=%0d dead=%0b want %h/%0d/%0b", pixel_out, hp_out, dead_out, m_pix, m_hp, m_dead);
            end
         end
      end
      for (int f = 0; f < 60; f++) frame(1'b0, 0);
      for (int c = 0; c < 96; c += 19) begin
         step(X + c, Y + 5, 1'b0, 1'b0);
         total++;
         if (pixel_out !== 12'hF00 || dead_out !== 1'b1) begin
            bad++; $display("FAIL dead_bar col%0d: got pix=%h dead=%0b want F00/1", c, pixel_out, dead_out);
         end
      end
      step(X + 96, Y + 5, 1'b0, 1'b0);
      total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL dead_outside: got %h want 000", pixel_out); end
   endtask

   task automatic test_saturate();
      rst2 = 1'b1; dmg2 = 1'b0; hc2 = 11'd1; vc2 = 10'd0;
      @(posedge clk); #1;
      rst2 = 1'b0;
      total++; if (hp2 !== 8'd6 || dead2 !== 1'b0) begin bad++; $display("FAIL sat_reset: got hp=%0d dead=%0b want 6/0", hp2, dead2); end
      dmg2 = 1'b1;
      @(posedge clk); #1;
      dmg2 = 1'b0;
      total++; if (hp2 !== 8'd2 || dead2 !== 1'b0) begin bad++; $display("FAIL sat_first: got hp=%0d dead=%0b want 2/0", hp2, dead2); end
      for (int f = 0; f < 10; f++) begin
         hc2 = 11'd0; vc2 = 10'd0;
         @(posedge clk); #1;
         hc2 = 11'd1;
         @(posedge clk); #1;
      end
      dmg2 = 1'b1;
      @(posedge clk); #1;
      dmg2 = 1'b0;
      total++; if (hp2 !== 8'd0 || dead2 !== 1'b1) begin bad++; $display("FAIL sat_second: got hp=%0d dead=%0b want 0/1", hp2, dead2); end
      @(posedge clk); #1;
      total++; if (hp2 !== 8'd0 || dead2 !== 1'b1) begin bad++; $display("FAIL sat_hold: got hp=%0d dead=%0b want 0/1", hp2, dead2); end
   endtask

   initial begin
      rst = 1'b1; damage = 1'b0; hc = 11'd1; vc = 10'd0;
      rst2 = 1'b1; dmg2 = 1'b0; hc2 = 11'd1; vc2 = 10'd0;
      m_pix = 12'h000;
      model_reset();
      test_reset();
      test_hold();
      test_iframes();
      test_blink();
      test_reset_mid();
      test_death();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
